// File: rtl/action_selector.sv
// rtl/action_selector.sv - epsilon-greedy action selector (LFSR explore / Q-table argmax exploit)
module action_selector #(
  parameter int          QW   = 16,
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 learning,
  input  logic [7:0]           epsilon,
  input  logic [11:0]          S,
  output logic                 q_rd,
  output logic [13:0]          q_addr,
  input  logic signed [QW-1:0] q_data,
  output logic [1:0]           A,
  output logic                 A_valid,
  output logic                 busy,
  output logic                 explore
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t                state, state_nxt;
  logic [15:0]           lfsr;
  logic [15:0]           lfsr_nxt;
  logic                  accept;
  logic                  explore_now;
  logic                  flag;
  logic [1:0]            rnd_a;
  logic [1:0]            idx;
  logic                  rd_d;
  logic [1:0]            rd_idx;
  logic signed [QW-1:0]  best_q;
  logic [1:0]            best_a;

  // Galois step and explore decision, both based on the advanced LFSR value
  always_comb begin
    lfsr_nxt    = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    accept      = (state == IDLE) && start;
    explore_now = learning && (lfsr_nxt[7:0] < epsilon);
  end

  // q_addr doubles as the latched state plus the fetch index
  assign idx = q_addr[1:0];

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // next-state and decode outputs
  always_comb begin
    state_nxt = state;
    q_rd      = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = explore_now ? DONE : FETCH;
      end
      FETCH: begin
        q_rd = 1'b1;
        if (idx == 2'd3) state_nxt = DRAIN;
      end
      DRAIN:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // LFSR advances once per accepted start; decision flag and random pick are latched with it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr  <= SEED;
      flag  <= 1'b0;
      rnd_a <= 2'd0;
    end else if (accept) begin
      lfsr  <= lfsr_nxt;
      flag  <= explore_now;
      rnd_a <= lfsr_nxt[9:8];
    end
  end

  // address generator: loaded on an exploit start, walks idx 0..3, holds while idle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_addr <= 14'd0;
    end else if (accept && !explore_now) begin
      q_addr <= {S, 2'd0};
    end else if (state == FETCH && idx != 2'd3) begin
      q_addr <= {q_addr[13:2], idx + 2'd1};
    end
  end

  // running argmax, one cycle behind the read; strict greater keeps the lowest index on ties
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_d   <= 1'b0;
      rd_idx <= 2'd0;
      best_q <= '0;
      best_a <= 2'd0;
    end else begin
      rd_d   <= q_rd;
      rd_idx <= idx;
      if (rd_d && (rd_idx == 2'd0 || q_data > best_q)) begin
        best_q <= q_data;
        best_a <= rd_idx;
      end
    end
  end

  // publish the decision with a one-cycle strobe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      A       <= 2'd0;
      explore <= 1'b0;
      A_valid <= 1'b0;
    end else begin
      A_valid <= (state == DONE);
      if (state == DONE) begin
        A       <= flag ? rnd_a : best_a;
        explore <= flag;
      end
    end
  end

endmodule

// File: tb/tb_action_selector.sv
// tb/tb_action_selector.sv - scoreboard bench for action_selector
module tb_action_selector;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               start = 1'b0;
  logic               learning = 1'b0;
  logic [7:0]         epsilon = 8'd0;
  logic [11:0]        S = 12'd0;
  logic               q_rd;
  logic [13:0]        q_addr;
  logic signed [15:0] q_data = '0;
  logic [1:0]         A;
  logic               A_valid;
  logic               busy;
  logic               explore;

  typedef struct {
    int a;
    int ex;
    int lat;
    int c0;
  } exp_t;

  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          av_cnt = 0;
  int          last_c0 = 0;
  int          qtab [4];
  logic [15:0] m_lfsr = 16'hACE1;
  exp_t        exp_q [$];
  exp_t        mon_e;
  logic [13:0] rd_addr [$];
  int          rd_cyc [$];

  action_selector #(.QW(16), .SEED(16'hACE1)) dut (
    .clk(clk), .rst(rst), .start(start), .learning(learning), .epsilon(epsilon),
    .S(S), .q_rd(q_rd), .q_addr(q_addr), .q_data(q_data), .A(A),
    .A_valid(A_valid), .busy(busy), .explore(explore)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  // cycle counter and synchronous Q-table model with read logging
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (q_rd) begin
      rd_addr.push_back(q_addr);
      rd_cyc.push_back(cyc);
      q_data <= 16'(qtab[q_addr[1:0]]);
    end
  end

  // scoreboard: pop and compare on every A_valid
  always @(negedge clk) begin
    if (A_valid) begin
      av_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_A_valid", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("A", int'(A), mon_e.a);
        chk("explore", int'(explore), mon_e.ex);
        chk("latency", cyc - 1 - mon_e.c0, mon_e.lat);
      end
    end
  end

  task automatic set_q(input int q0, input int q1, input int q2, input int q3);
    qtab[0] = q0; qtab[1] = q1; qtab[2] = q2; qtab[3] = q3;
  endtask

  task automatic run_decision(input logic [11:0] s, input bit lrn, input int eps, input int poke);
    logic [15:0] l;
    int          ex;
    int          a;
    int          best;
    exp_t        e;
    @(negedge clk);
    S = s; learning = lrn; epsilon = eps[7:0]; start = 1'b1;
    l = lfsr_step(m_lfsr);
    m_lfsr = l;
    ex = (lrn && (l[7:0] < eps[7:0])) ? 1 : 0;
    if (ex == 1) begin
      a = int'(l[9:8]);
    end else begin
      best = qtab[0]; a = 0;
      for (int k = 1; k < 4; k++) if (qtab[k] > best) begin best = qtab[k]; a = k; end
    end
    e.a = a; e.ex = ex; e.lat = (ex == 1) ? 1 : 6; e.c0 = cyc;
    last_c0 = cyc;
    exp_q.push_back(e);
    rd_addr.delete();
    rd_cyc.delete();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      start = (i == poke);
      S = ~s;
      #1;
      if (exp_q.size() == 0) break;
    end
    start = 1'b0;
    if (exp_q.size() != 0) begin
      chk("timeout_waiting_A_valid", 0, 1);
      exp_q.delete();
    end
  endtask

  task automatic check_reads(input logic [11:0] s);
    chk("n_reads", rd_addr.size(), 4);
    for (int k = 0; k < 4 && k < rd_addr.size(); k++) begin
      chk("q_addr", int'(rd_addr[k]), int'({s, 2'(k)}));
      chk("rd_cycle", rd_cyc[k] - last_c0, k + 1);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    m_lfsr = 16'hACE1;
  endtask

  initial begin
    int av0;
    int c0;
    set_q(0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("rst_A", int'(A), 0);
    chk("rst_A_valid", int'(A_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_q_rd", int'(q_rd), 0);
    chk("rst_explore", int'(explore), 0);
    chk("rst_q_addr", int'(q_addr), 0);
    rst = 1'b1;

    set_q(10, -5, 30, 30);
    run_decision(12'h5A3, 1'b0, 0, -1);
    check_reads(12'h5A3);
    chk("argmax_A", int'(A), 2);

    set_q(-100, -3, -50, -3);
    run_decision(12'h123, 1'b0, 0, -1);
    check_reads(12'h123);
    chk("neg_tie_A", int'(A), 1);

    do_reset();
    set_q(1, 2, 3, 4);
    run_decision(12'hABC, 1'b1, 113, -1);
    chk("explore_seed_reads", rd_addr.size(), 0);
    chk("explore_seed_A", int'(A), 2);
    chk("explore_seed_flag", int'(explore), 1);

    do_reset();
    set_q(0, 0, 7, 0);
    run_decision(12'h0F0, 1'b1, 112, -1);
    check_reads(12'h0F0);
    chk("eps112_flag", int'(explore), 0);

    set_q(5, 9, 1, 2);
    av0 = av_cnt;
    run_decision(12'h777, 1'b0, 0, 1);
    repeat (10) @(negedge clk);
    chk("busy_start_single_valid", av_cnt - av0, 1);
    check_reads(12'h777);

    for (int t = 0; t < 8; t++) begin
      set_q($urandom_range(0, 400) - 200, $urandom_range(0, 400) - 200,
            $urandom_range(0, 400) - 200, $urandom_range(0, 400) - 200);
      run_decision(12'($urandom), 1'b1, (t % 4 == 0) ? 0 : 160, -1);
    end
    set_q(3, 3, 3, 3);
    run_decision(12'h321, 1'b0, 255, -1);
    chk("nolearn_flag", int'(explore), 0);

    set_q(1, 2, 3, 4);
    run_decision(12'h456, 1'b0, 0, -1);
    chk("pre_abort_A", int'(A), 3);
    @(negedge clk);
    S = 12'h999; learning = 1'b0; start = 1'b1;
    c0 = cyc;
    @(negedge clk);
    start = 1'b0;
    while (cyc < c0 + 4) @(posedge clk);
    #1;
    chk("abort_busy_before", int'(busy), 1);
    #1;
    rst = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_q_rd", int'(q_rd), 0);
    chk("abort_A", int'(A), 0);
    av0 = av_cnt;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    m_lfsr = 16'hACE1;
    repeat (8) @(negedge clk);
    chk("abort_no_valid", av_cnt - av0, 0);
    run_decision(12'h5A3, 1'b1, 113, -1);
    chk("post_abort_A", int'(A), 2);
    chk("post_abort_reads", rd_addr.size(), 0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/action_selector.md
# action_selector

Epsilon-greedy policy stage that sits directly upstream of the environment simulator and drives its 2-bit action input. On each `start` pulse it either explores, picking a pseudo-random action from an internal LFSR, or exploits. To exploit, it reads the four Q-values for the current 12-bit state from the Q-table over a synchronous read port and selects the argmax. It then presents the chosen action with a one-cycle `A_valid` strobe.

## Interface
- `QW`, 16: Q-value width, two's-complement signed.
- `SEED`, 16'hACE1: LFSR reset value; must be nonzero.
- `clk` input 1: sole clock; all state updates on the rising edge.
- `rst` input 1: reset, asynchronous, active-low. Asserting it (low) clears all state immediately.
- `start` input 1: request a decision for `S`; sampled only in IDLE.
- `learning` input 1: 1 enables exploration; 0 forces pure exploit.
- `epsilon` input 8: exploration threshold; explore when `lfsr[7:0] < epsilon`.
- `S` input 12: current state `{L3,L2,L1,L0}` (3 bits per lane); latched on accepted `start`.
- `q_rd` output 1: Q-table read enable.
- `q_addr` output 14: `{S_lat, idx[1:0]}`.
- `q_data` input QW: Q-table read data; valid the cycle after `q_rd`.
- `A` output 2: chosen action; holds until the next decision completes.
- `A_valid` output 1: single-cycle pulse when `A` updates.
- `busy` output 1: high in every state except IDLE.
- `explore` output 1: 1 if the last decision was random; updates with `A`.

## Operation
- LFSR: 16-bit Galois, right shift, `next = (l>>1) ^ (l[0] ? 16'hB400 : 0)`.
  - Advances exactly once per accepted `start`.
  - The decision uses the advanced value.
  - Never reaches zero.
- Explore condition: `learning && (lfsr_next[7:0] < epsilon)`, unsigned.
  - `epsilon=0` never explores.
  - `learning=0` never explores, whatever `epsilon` is.
- States:
  - IDLE: `start=1` latches `S`, advances the LFSR, then goes to DONE if exploring, else FETCH with `idx=0`.
  - FETCH: `q_rd=1`, `q_addr={S_lat,idx}`, idx increments 0→3. After idx=3, go to DRAIN.
  - DRAIN: one cycle, captures the last `q_data`, then goes to DONE.
  - DONE: `A <= choice`, `explore <= flag`, `A_valid=1`; return to IDLE.
- Comparison: signed, QW bits, pipelined one cycle behind the address.
  - idx0 data initialises `best_q`/`best_a`.
  - Each later idx replaces the best only if strictly greater, so ties keep the lowest index.
- Explore choice: `lfsr_next[9:8]`.
- `start` while `busy` is ignored; it is neither queued nor does it advance the LFSR.
- `S` changes after the accepted `start` have no effect on the in-flight decision.
- Reset values: `A=0`, `A_valid=0`, `explore=0`, `busy=0`, `q_rd=0`, `q_addr=0`, `lfsr=SEED`, state IDLE, internal best registers 0.
- Reset asserted mid-decision aborts it. `A` returns to 0 and no `A_valid` is issued.

## Timing
- Cycle 0 is the edge at which `start` is sampled in IDLE.
- Exploit path:
  - `q_rd` high in cycles 1–4, with idx 0,1,2,3.
  - `q_data` for idx k is sampled in cycle k+2.
  - DRAIN in cycle 5, `A_valid` in cycle 6. Latency 6.
- Explore path: `A_valid` in cycle 1. Latency 1, with no Q-table access.
- `A` and `explore` change on the same edge that raises `A_valid`.
- A new `start` is accepted in the cycle after DONE at the earliest.
- `q_rd` is never high outside FETCH; `q_addr` holds its last value when idle.

## Test plan
- Reset: hold `rst=0`, toggle `clk` → `A=0`, `A_valid=0`, `busy=0`, `q_rd=0`, `explore=0`.
- Exploit argmax: `learning=0`, `S=12'h5A3`, Q-table returns idx0..3 = {10,-5,30,30}.
  - Required: `q_addr` sequence 14'h168C..14'h168F.
  - Required: `A=2`, `explore=0`, `A_valid` exactly at cycle 6.
- All negative: Q = {-100,-3,-50,-3} → `A=1` (tie resolved to the lower index, signed compare).
- Explore from seed: after reset, `learning=1`, `epsilon=113`, `start` → `A_valid` at cycle 1, `A=2`, `explore=1`, no `q_rd`.
  - Repeat from reset with `epsilon=112` → exploit path taken.
- Busy/reset: pulse `start` during FETCH → ignored, single `A_valid`.
  - Drive `rst=0` asynchronously in cycle 3 → `busy` drops immediately, no `A_valid`, next decision behaves as from power-up.
